ring_injection_arbiter: RTL
===========================

RING_INJECTION_ARBITER -- requirements
Module: ring_injection_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of local requesters sharing one ring endpoint injection port.
REQ-002 Parameter DEST_WIDTH, default 4: destination field width.
REQ-003 Parameter FLIT_WIDTH, default 256: flit payload width.
REQ-004 Parameter FLIT_BUFFER_DEPTH, default 2: downstream router input buffer depth; initial and maximum credit count.
REQ-005 Port clk, input, 1: sole clock; all state on rising edge.
REQ-006 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Port req_data, input, FLIT_WIDTH x [NUM_REQ]: per-requester flit payload.
REQ-008 Port req_dest, input, DEST_WIDTH x [NUM_REQ]: per-requester destination.
REQ-009 Port req_is_tail, input, 1 x [NUM_REQ]: flit is last of packet.
REQ-010 Port req_valid, input, 1 x [NUM_REQ]: requester presents a flit.
REQ-011 Port req_ready, output, 1 x [NUM_REQ]: flit accepted this cycle when valid and ready are both high.
REQ-012 Port data_out / dest_out / is_tail_out, output, FLIT_WIDTH / DEST_WIDTH / 1: registered flit to router port 0.
REQ-013 Port send_out, output, 1: data_out/dest_out/is_tail_out valid this cycle.
REQ-014 Port credit_in, input, 1: one buffer slot returned by the router.
REQ-015 Port busy, output, 1: high while state is LOCKED.
REQ-016 Port credit_err, output, 1: sticky; set when credit_in arrives with the counter at FLIT_BUFFER_DEPTH.

Function
REQ-017 Credit counter width is $clog2(FLIT_BUFFER_DEPTH+1); it decrements on send_out, increments on credit_in, and holds when both are high in the same cycle.
REQ-018 credit_in with counter at max and no send_out in that cycle: counter holds and credit_err sets.
REQ-019 A flit is accepted only when the registered counter minus pending send (send_out this cycle) is >0; credit_in in the same cycle does not enable acceptance until the next cycle.
REQ-020 FSM states are IDLE and LOCKED, with a round-robin pointer rr_ptr in range 0..NUM_REQ-1.
REQ-021 IDLE with credit available: winner is the first req_valid at or after rr_ptr, searched cyclically; only the winner's req_ready is high.
REQ-022 IDLE, winner flit non-tail: owner is latched to the winner and the next state is LOCKED.
REQ-023 IDLE, winner flit tail (single-flit packet): stay IDLE and set rr_ptr to (winner+1) mod NUM_REQ.
REQ-024 LOCKED: only owner's req_ready may be high (credit available); other requesters are blocked regardless of valid.
REQ-025 LOCKED, owner tail accepted: next state IDLE, rr_ptr becomes (owner+1) mod NUM_REQ.
REQ-026 LOCKED with owner req_valid low: hold LOCKED with no injection; wormhole packets are never interleaved.
REQ-027 req_ready is combinational from state, counter, send_out and req_valid; it never depends on the same-cycle credit_in.
REQ-028 Latency: accepted flit appears on outputs with send_out=1 exactly one cycle after acceptance, one flit per cycle max.
REQ-029 When no flit is accepted, send_out=0 and data_out/dest_out/is_tail_out hold their previous values.
REQ-030 No valid requester, or no credit: no req_ready high, and state and rr_ptr unchanged.

Reset
REQ-031 While rst_n=0, outputs are: send_out=0, data_out=0, dest_out=0, is_tail_out=0, busy=0, credit_err=0, all req_ready=0.
REQ-032 While rst_n=0, internal state is: credit counter=FLIT_BUFFER_DEPTH, state=IDLE, rr_ptr=0, owner=0.
REQ-033 Reset mid-packet abandons the packet, restores full credit and returns to IDLE; the router is reset together with this block.

Verification
REQ-034 Single flit, 0 latency check: reset, req_valid[2]=1, is_tail=1, dest=3 -> req_ready[2]=1 that cycle, next cycle send_out=1, dest_out=3, rr_ptr=3.
REQ-035 Credit stall: DEPTH=2, no credit_in, requester 0 streams a 4-flit packet -> two flits sent, then req_ready[0]=0; one credit_in -> third flit sent the cycle after.
REQ-036 Wormhole lock: req 1 mid-packet, req 0 and 3 valid -> only req 1 served until its tail, then req 3, then req 0 (round-robin from 2).
REQ-037 Fairness: all 4 requesters hold valid single-flit packets with credit recycled every cycle -> grant order 0,1,2,3,0,... with no starvation.
REQ-038 Simultaneous send and credit_in at counter=1 -> counter stays 1; credit_in at counter=2 with no send -> credit_err=1 and stays set until reset.
REQ-039 Reset asserted in LOCKED after 2 of 3 flits -> all outputs at reset values immediately, counter=2 and IDLE after release.

Source files
------------

// File: rtl/ring_injection_arbiter.sv
// Ring endpoint injection arbiter: round-robin over local requesters,
// wormhole packet locking and credit-based flow control toward router port 0.
module ring_injection_arbiter #(
  parameter int NUM_REQ           = 4,
  parameter int DEST_WIDTH        = 4,
  parameter int FLIT_WIDTH        = 256,
  parameter int FLIT_BUFFER_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FLIT_WIDTH-1:0] req_data [NUM_REQ],
  input  logic [DEST_WIDTH-1:0] req_dest [NUM_REQ],
  input  logic [NUM_REQ-1:0]    req_is_tail,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0] dest_out,
  output logic                  is_tail_out,
  output logic                  send_out,
  input  logic                  credit_in,
  output logic                  busy,
  output logic                  credit_err
);

  localparam int CW = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CW-1:0] MAX_CRED = CW'(FLIT_BUFFER_DEPTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);
  localparam logic [PW:0]   NUM_EXT  = (PW + 1)'(NUM_REQ);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] owner;
  logic [CW-1:0] credits;

  logic          cred_ok;
  logic          win_found;
  logic [PW-1:0] win;
  logic [PW-1:0] grant_idx;
  logic          accept;
  logic          grant_tail;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

  // A slot is free only after discounting the flit leaving this cycle
  assign cred_ok = credits > CW'(send_out);

  // Cyclic search for the first valid requester at or after rr_ptr
  always_comb begin : win_search
    logic [PW:0] idx;
    win_found = 1'b0;
    win       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (PW + 1)'(k);
      if (idx >= NUM_EXT) idx = idx - NUM_EXT;
      if (!win_found && req_valid[idx[PW-1:0]]) begin
        win_found = 1'b1;
        win       = idx[PW-1:0];
      end
    end
  end

  // Grant: search winner when idle, owner only while locked
  always_comb begin
    req_ready = '0;
    grant_idx = win;
    if (rst_n && cred_ok) begin
      unique case (state)
        IDLE: begin
          if (win_found) req_ready[win] = 1'b1;
        end
        LOCKED: begin
          grant_idx        = owner;
          req_ready[owner] = req_valid[owner];
        end
        default: req_ready = '0;
      endcase
    end
  end

  assign accept     = |(req_ready & req_valid);
  assign grant_tail = req_is_tail[grant_idx];

  // Registered flit toward the router; holds when nothing is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      send_out    <= 1'b0;
      data_out    <= '0;
      dest_out    <= '0;
      is_tail_out <= 1'b0;
    end else begin
      send_out <= accept;
      if (accept) begin
        data_out    <= req_data[grant_idx];
        dest_out    <= req_dest[grant_idx];
        is_tail_out <= grant_tail;
      end
    end
  end

  // Credit counter with sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits    <= MAX_CRED;
      credit_err <= 1'b0;
    end else begin
      if (credit_in && !send_out) begin
        if (credits == MAX_CRED) credit_err <= 1'b1;
        else credits <= credits + CW'(1);
      end else if (send_out && !credit_in) begin
        credits <= credits - CW'(1);
      end
    end
  end

  // Arbitration FSM: lock onto a packet until its tail is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (grant_tail) begin
              rr_ptr <= wrap_inc(grant_idx);
            end else begin
              owner <= grant_idx;
              state <= LOCKED;
              busy  <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (accept && grant_tail) begin
            state  <= IDLE;
            busy   <= 1'b0;
            rr_ptr <= wrap_inc(owner);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
